// File: rtl/idecode_pkg.sv
// Shared decode-stage definitions: opcodes, control-field layout and the bubble value.
package idecode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam int EX_W = 4;
   localparam int M_W  = 3;
   localparam int WB_W = 2;

   // EX = {regdst, aluop[1:0], alusrc}
   localparam int EX_REGDST   = 3;
   localparam int EX_ALUOP_HI = 2;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_ALUSRC   = 0;

   // M = {branch, memread, memwrite}
   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   // WB = {regwrite, memtoreg}
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   typedef struct packed {
      logic [EX_W-1:0] ex;
      logic [M_W-1:0]  m;
      logic [WB_W-1:0] wb;
   } ctl_t;

   localparam ctl_t CTL_BUBBLE = '0;

endpackage

// File: rtl/idecode_pipe_if.sv
// IF/ID input, writeback port and ID/EX output bundle of the decode stage.
interface idecode_pipe_if #(
   parameter int XLEN = 32
);
   logic [31:0]      if_id_instr;
   logic [XLEN-1:0]  if_id_npc;
   logic             flush;
   logic [4:0]       wb_rd;
   logic             wb_regwrite;
   logic [XLEN-1:0]  wb_data;

   logic             stall;
   logic             illegal;
   logic [1:0]       wb_ctlout;
   logic [2:0]       m_ctlout;
   logic             regdst;
   logic             alusrc;
   logic [1:0]       aluop;
   logic [XLEN-1:0]  npcout;
   logic [XLEN-1:0]  rdata1out;
   logic [XLEN-1:0]  rdata2out;
   logic [XLEN-1:0]  s_extendout;
   logic [4:0]       instrout_2016;
   logic [4:0]       instrout_1511;
   logic [4:0]       instrout_2521;

   modport master (
      output if_id_instr, if_id_npc, flush, wb_rd, wb_regwrite, wb_data,
      input  stall, illegal, wb_ctlout, m_ctlout, regdst, alusrc, aluop,
             npcout, rdata1out, rdata2out, s_extendout,
             instrout_2016, instrout_1511, instrout_2521
   );

   modport slave (
      input  if_id_instr, if_id_npc, flush, wb_rd, wb_regwrite, wb_data,
      output stall, illegal, wb_ctlout, m_ctlout, regdst, alusrc, aluop,
             npcout, rdata1out, rdata2out, s_extendout,
             instrout_2016, instrout_1511, instrout_2521
   );
endinterface

// File: rtl/idecode_pipe_regfile_bypass.sv
// Two-read one-write register file with r0 hardwired to zero and optional write-through bypass.
module regfile_bypass #(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter bit RAW_BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);

   localparam logic [5:0] NREG_L = 6'(NREG);

   logic [XLEN-1:0] regs [NREG];
   logic            wr_ok;
   logic            ra1_ok;
   logic            ra2_ok;

   assign wr_ok  = we && (wa != 5'd0) && ({1'b0, wa} < NREG_L);
   assign ra1_ok = (ra1 != 5'd0) && ({1'b0, ra1} < NREG_L);
   assign ra2_ok = (ra2 != 5'd0) && ({1'b0, ra2} < NREG_L);

   // NOTE: the whole array is cleared on reset, so this cannot map onto a RAM macro;
   // the decode stage relies on every register reading 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1_ok) rd1 = (RAW_BYPASS && wr_ok && (wa == ra1)) ? wd : regs[ra1];
      if (ra2_ok) rd2 = (RAW_BYPASS && wr_ok && (wa == ra2)) ? wd : regs[ra2];
   end

endmodule

// File: rtl/idecode_pipe.sv
// MIPS decode stage: control decode, register read, sign extension, load-use hazard
// detection and the ID/EX pipeline register.
module idecode_pipe
   import idecode_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter bit RAW_BYPASS = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   idecode_pipe_if.slave bus
);

   logic [5:0]      opcode;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic [XLEN-1:0] s_extend;
   ctl_t            dec_ctl;
   logic            dec_legal;
   logic            hazard;
   logic            bubble;

   ctl_t            ctl_q;
   logic            illegal_q;
   logic [XLEN-1:0] npc_q;
   logic [XLEN-1:0] rdata1_q;
   logic [XLEN-1:0] rdata2_q;
   logic [XLEN-1:0] s_extend_q;
   logic [4:0]      rt_q;
   logic [4:0]      rd_q;
   logic [4:0]      rs_q;

   assign opcode   = bus.if_id_instr[31:26];
   assign rs       = bus.if_id_instr[25:21];
   assign rt       = bus.if_id_instr[20:16];
   assign rd       = bus.if_id_instr[15:11];
   assign s_extend = {{(XLEN-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};

   regfile_bypass #(
      .XLEN       (XLEN),
      .NREG       (NREG),
      .RAW_BYPASS (RAW_BYPASS)
   ) u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (rdata1),
      .rd2 (rdata2),
      .we  (bus.wb_regwrite),
      .wa  (bus.wb_rd),
      .wd  (bus.wb_data)
   );

   // NOTE: every output of a combinational block gets a default first, so an
   // unlisted opcode cannot leave a control bit latched from a previous value.
   always_comb begin
      dec_ctl   = CTL_BUBBLE;
      dec_legal = 1'b1;
      case (opcode)
         OP_RTYPE: begin dec_ctl.ex = 4'b1100; dec_ctl.m = 3'b000; dec_ctl.wb = 2'b10; end
         OP_LW:    begin dec_ctl.ex = 4'b0001; dec_ctl.m = 3'b010; dec_ctl.wb = 2'b11; end
         OP_SW:    begin dec_ctl.ex = 4'b0001; dec_ctl.m = 3'b001; dec_ctl.wb = 2'b00; end
         OP_BEQ:   begin dec_ctl.ex = 4'b0010; dec_ctl.m = 3'b100; dec_ctl.wb = 2'b00; end
         OP_ADDI:  begin dec_ctl.ex = 4'b0001; dec_ctl.m = 3'b000; dec_ctl.wb = 2'b10; end
         default:  dec_legal = 1'b0;
      endcase
   end

   // A load in ID/EX whose destination is a source of the instruction now in decode.
   assign hazard = ctl_q.m[M_MEMREAD] && (rt_q != 5'd0) && ((rt_q == rs) || (rt_q == rt));
   assign bubble = bus.flush || hazard;

   // NOTE: sequential state uses non-blocking assignments so all ID/EX fields
   // update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctl_q      <= CTL_BUBBLE;
         illegal_q  <= 1'b0;
         npc_q      <= '0;
         rdata1_q   <= '0;
         rdata2_q   <= '0;
         s_extend_q <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         rs_q       <= '0;
      end else begin
         ctl_q      <= bubble ? CTL_BUBBLE : dec_ctl;
         illegal_q  <= bubble ? 1'b0 : !dec_legal;
         npc_q      <= bus.if_id_npc;
         rdata1_q   <= rdata1;
         rdata2_q   <= rdata2;
         s_extend_q <= s_extend;
         rt_q       <= rt;
         rd_q       <= rd;
         rs_q       <= rs;
      end
   end

   assign bus.stall         = hazard;
   assign bus.illegal       = illegal_q;
   assign bus.wb_ctlout     = {ctl_q.wb[WB_REGWRITE], ctl_q.wb[WB_MEMTOREG]};
   assign bus.m_ctlout      = {ctl_q.m[M_BRANCH], ctl_q.m[M_MEMREAD], ctl_q.m[M_MEMWRITE]};
   assign bus.regdst        = ctl_q.ex[EX_REGDST];
   assign bus.aluop         = ctl_q.ex[EX_ALUOP_HI:EX_ALUOP_LO];
   assign bus.alusrc        = ctl_q.ex[EX_ALUSRC];
   assign bus.npcout        = npc_q;
   assign bus.rdata1out     = rdata1_q;
   assign bus.rdata2out     = rdata2_q;
   assign bus.s_extendout   = s_extend_q;
   assign bus.instrout_2016 = rt_q;
   assign bus.instrout_1511 = rd_q;
   assign bus.instrout_2521 = rs_q;

endmodule

// File: doc/idecode_pipe.md
Name: idecode_pipe

Overview:
- Parametrised decode stage for the 5-stage MIPS pipeline: control decode, register file with write-through bypass, sign extension and the ID/EX pipeline register in one block.
- Adds load-use hazard detection (stall request to fetch plus bubble insertion), a branch flush input, and an illegal-opcode flag.
- Sits between the IF/ID latch and the execute stage; the writeback stage drives the register write port.

Parameters:
- XLEN, 32, datapath width: register data, npc and extended immediate.
- NREG, 32, register count; the address width is fixed at 5, and addresses at or above NREG read 0 and ignore writes.
- RAW_BYPASS, 1, 1 forwards same-cycle writeback data to the decode read ports; 0 makes reads see the old value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- if_id_instr  in  32  instruction from the IF/ID latch.
- if_id_npc  in  XLEN  PC+4 from the IF/ID latch.
- flush  in  1  branch taken; the current decode instruction becomes a bubble.
- wb_rd  in  5  writeback destination register.
- wb_regwrite  in  1  writeback enable.
- wb_data  in  XLEN  writeback data.
- stall  out  1  combinational load-use hazard; fetch holds PC and IF/ID when high.
- illegal  out  1  registered; high when the ID/EX slot holds an undecoded opcode.
- wb_ctlout  out  2  {regwrite, memtoreg}.
- m_ctlout  out  3  {branch, memread, memwrite}.
- regdst, alusrc  out  1 each  EX controls.
- aluop  out  2  ALU operation class.
- npcout, rdata1out, rdata2out, s_extendout  out  XLEN each  registered datapath values.
- instrout_2016, instrout_1511, instrout_2521  out  5 each  rt, rd and rs for the execute-stage forwarding unit.

Behaviour:
- Reset: on a rising edge with rst=1, all ID/EX outputs, illegal and every register-file entry become 0. Reset overrides flush, stall and the write port.
- Decode is combinational on opcode [31:26] and produces EX={regdst,aluop,alusrc}, M and WB:
  - 000000 R-type: EX=1100, M=000, WB=10.
  - 100011 lw: EX=0001, M=010, WB=11.
  - 101011 sw: EX=0001, M=001, WB=00.
  - 000100 beq: EX=0010, M=100, WB=00.
  - 001000 addi: EX=0001, M=000, WB=10.
  - Any other opcode: all controls 0, and illegal is set when the instruction is latched.
- Register file:
  - Write on the rising edge when wb_regwrite=1, wb_rd!=0 and wb_rd<NREG.
  - Register 0 always reads 0.
  - Reads are combinational on rs [25:21] and rt [20:16].
  - With RAW_BYPASS=1, a read whose address equals wb_rd, under valid write conditions, returns wb_data in the same cycle.
- Sign extend: instr[15] is replicated into bits XLEN-1:16.
- Hazard detection: stall = m_ctlout[1] & (instrout_2016!=0) & (instrout_2016==rs | instrout_2016==rt). Evaluated against the current ID/EX contents.
- ID/EX update on every rising edge, in priority order:
  1. rst: clear.
  2. flush or stall: load a bubble. WB, M, EX controls and illegal become 0; datapath fields load normally (don't-care).
  3. Otherwise: load the decoded controls and datapath values.
- Latency: one cycle from if_id_instr to registered outputs.
- Stall lasts exactly one cycle per load-use pair: after the bubble, memread in ID/EX is 0.
- flush and stall together: flush wins. stall output still reflects the hazard; fetch gives flush priority.
- Simultaneous write and read of the same register follows RAW_BYPASS. A write to reg 0 is dropped, and reg 0 is never bypassed.
- Reset mid-stall: stall deasserts on the following cycle because ID/EX is cleared.

Decomposition:
- Shared package idecode_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI).
  - control-field widths and the bubble constant.
  - EX/M/WB bit-position constants.
- One sub-module, regfile_bypass, holding the register array, reset clear and the RAW_BYPASS read mux.
- Control decode, hazard logic and the ID/EX register stay inline.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, stall=0, and reads of r1..r31 return 0.
- R-type add $3,$1,$2 with r1=5, r2=7 preloaded via the wb port -> next cycle wb_ctlout=10, regdst=1, aluop=10, rdata1out=5, rdata2out=7, instrout_1511=3.
- Bypass: wb_rd=4, wb_data=0xDEAD, and decode of an instruction with rs=4 in the same cycle -> rdata1out=0xDEAD with RAW_BYPASS=1; old value (0) with RAW_BYPASS=0.
- Load-use: lw $2,8($1) followed by add $4,$2,$3 -> stall=1 for exactly one cycle, a bubble (all controls 0) enters ID/EX, and add is latched on the next cycle.
- Flush plus sign extend: addi with imm=0xFFF0 and flush=1 -> bubble latched. Same instruction with flush=0 -> s_extendout=0xFFFFFFF0, alusrc=1.
- Illegal opcode 111111 -> illegal=1 and controls 0 next cycle; writes to r0 with wb_data=0x1 leave r0 reading 0.
